// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte (write or read), STOP, with a fixed 20 bit-period frame.
// Optional clock stretching on the high half of SCL is enabled by defining I2C_MASTER_STRETCH_EN.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl_out,
    output logic       sda_enable,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RNACK, STOP
    } state_t;

    state_t      state;
    logic [1:0]  quarter;
    logic [4:0]  bit_num;
    logic [7:0]  div_cnt;
    logic [7:0]  addr_byte;
    logic [7:0]  wdata_q;
    logic        hold;
    logic        tick;

`ifdef I2C_MASTER_STRETCH_EN
    assign hold = quarter[1] && scl_out && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    assign tick = (div_cnt == 8'(CLK_DIV - 1)) && !hold;

    // bit_num counts bit periods across the whole frame: 0 START, 1-8 address, 9 ACK, 10-17 data, 18 ACK/NACK, 19 STOP
    function automatic state_t next_state(state_t s, logic [4:0] b, logic r, logic nack);
        state_t n;
        n = s;
        case (s)
            START:     n = ADDR;
            ADDR:      n = (b == 5'd8) ? ADDR_ACK : ADDR;
            ADDR_ACK:  n = nack ? STOP : (r ? RDATA : WDATA);
            WDATA:     n = (b == 5'd17) ? WDATA_ACK : WDATA;
            RDATA:     n = (b == 5'd17) ? RNACK : RDATA;
            WDATA_ACK: n = STOP;
            RNACK:     n = STOP;
            default:   n = s;
        endcase
        return n;
    endfunction

    // Returns {scl, sda_enable} for a given frame position
    function automatic logic [1:0] line_drive(state_t s, logic [1:0] q, logic [4:0] b,
                                              logic [7:0] ab, logic [7:0] wd);
        logic [1:0] d;
        case (s)
            IDLE:  d = 2'b10;
            START: d = {1'b1, q[1]};
            ADDR:  d = {q[1], !ab[3'(5'd8 - b)]};
            WDATA: d = {q[1], !wd[3'(5'd17 - b)]};
            STOP: begin
                // An address NACK parks the bus with SCL and SDA low until the final bit slot
                if (b != 5'd19) d = 2'b01;
                else if (q == 2'd0) d = 2'b01;
                else if (q == 2'd1) d = 2'b11;
                else d = 2'b10;
            end
            default: d = {q[1], 1'b0};
        endcase
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            quarter    <= 2'd0;
            bit_num    <= 5'd0;
            div_cnt    <= 8'd0;
            addr_byte  <= 8'd0;
            wdata_q    <= 8'd0;
            scl_out    <= 1'b1;
            sda_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            rdata      <= 8'd0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !done) begin
                    state      <= START;
                    quarter    <= 2'd0;
                    bit_num    <= 5'd0;
                    div_cnt    <= 8'd0;
                    addr_byte  <= {addr, rw};
                    wdata_q    <= wdata;
                    busy       <= 1'b1;
                    ack_err    <= 1'b0;
                    scl_out    <= 1'b1;
                    sda_enable <= 1'b0;
                end
            end else if (!tick) begin
                if (!hold) div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= 8'd0;
                if (quarter == 2'd2) begin
                    case (state)
                        ADDR_ACK, WDATA_ACK: ack_err <= sda_in;
                        RDATA:               rdata   <= {rdata[6:0], sda_in};
                        default: ;
                    endcase
                end
                if (quarter != 2'd3) begin
                    quarter <= quarter + 2'd1;
                    {scl_out, sda_enable} <= line_drive(state, quarter + 2'd1, bit_num, addr_byte, wdata_q);
                end else if (bit_num == 5'd19) begin
                    state      <= IDLE;
                    quarter    <= 2'd0;
                    bit_num    <= 5'd0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    scl_out    <= 1'b1;
                    sda_enable <= 1'b0;
                end else begin
                    quarter <= 2'd0;
                    bit_num <= bit_num + 5'd1;
                    state   <= next_state(state, bit_num, addr_byte[0], ack_err);
                    {scl_out, sda_enable} <= line_drive(next_state(state, bit_num, addr_byte[0], ack_err),
                                                        2'd0, bit_num + 5'd1, addr_byte, wdata_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl: a behavioural I2C slave on the wire plus a transaction-level
// reference model for the bytes on SDA, ack_err, rdata, done latency and START/STOP conditions.
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       sda_in;
    logic       scl_in;
    logic       scl_out, sda_enable, busy, done, ack_err;
    logic [7:0] rdata;

    int tests = 0;
    int fails = 0;

    // Slave behaviour for the current transaction
    logic       t_rw = 1'b0, t_aack = 1'b0, t_dack = 1'b0;
    logic [7:0] t_rbyte = 8'd0;
    logic       stretch_low = 1'b0;
    logic [7:0] exp_rdata = 8'd0;

    // Bus monitor state
    logic slave_low = 1'b0;
    logic prev_scl = 1'b1, prev_sda = 1'b1, rel18 = 1'b0;
    int   starts = 0, stops = 0, rises = 0;
    logic line_bits [0:18];
    logic sda_line;

    assign sda_line = !sda_enable && !slave_low;
    assign sda_in   = sda_line;
    assign scl_in   = scl_out && !stretch_low;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .sda_in(sda_in), .scl_in(scl_in), .scl_out(scl_out), .sda_enable(sda_enable),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic logic slave_pull(int nb);
        if (nb == 9) return t_aack;
        if (nb >= 10 && nb <= 17) return t_rw && t_aack && !t_rbyte[17 - nb];
        if (nb == 18) return !t_rw && t_aack && t_dack;
        return 1'b0;
    endfunction

    // Decode the open-drain bus: START/STOP conditions, bit values at SCL rise, slave drive at SCL fall
    always @(negedge clk) begin
        prev_scl <= scl_out;
        prev_sda <= sda_line;
        if (rst) begin
            slave_low <= 1'b0;
            rises     <= 0;
        end else begin
            if (prev_scl && scl_out && prev_sda && !sda_line) begin
                starts    <= starts + 1;
                rises     <= 0;
                slave_low <= 1'b0;
            end else if (prev_scl && scl_out && !prev_sda && sda_line) begin
                stops <= stops + 1;
            end
            if (!prev_scl && scl_out) begin
                rises <= rises + 1;
                if (rises < 19) line_bits[rises] <= sda_line;
                if (rises == 17) rel18 <= !sda_enable;
            end
            if (prev_scl && !scl_out) slave_low <= slave_pull(rises + 1);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // mode: 0 plain, 1 extra start at cycle 100, 2 reset during data bit 3, 3 stretch 50 cycles in address bit 2
    task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] wd,
                                 input logic aack, input logic dack, input logic [7:0] rb, input int mode);
        int cyc, dones, exp_lat, base_starts, base_stops, stretch_left;
        logic stretched;
        logic [7:0] abyte, dbyte;
        t_rw = r; t_aack = aack; t_dack = dack; t_rbyte = rb;
        exp_lat = 80 * CLK_DIV + ((mode == 3) ? 50 : 0);
        stretched = 1'b0;
        stretch_left = 0;
        @(negedge clk);
        base_starts = starts;
        base_stops  = stops;
        addr = a; rw = r; wdata = wd; start = 1'b1;
        @(posedge clk);
        cyc = 0;
        dones = 0;
        @(negedge clk);
        start = 1'b0; addr = ~a; rw = ~r; wdata = ~wd;
        checkOutput("busy_after_start", busy, 1);
        while (dones == 0 && cyc < exp_lat + 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (mode == 1 && cyc == 100);
            if (done) dones++;
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) stretch_low = 1'b0;
            end else if (mode == 3 && !stretched && cyc > 12 && rises == 2) begin
                stretched = 1'b1;
                stretch_low = 1'b1;
                stretch_left = 50;
            end
            if (mode == 2 && cyc > 12 && rises == 13) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checkOutput("rst_scl_out", scl_out, 1);
                checkOutput("rst_sda_enable", sda_enable, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_ack_err", ack_err, 0);
                checkOutput("rst_rdata", rdata, 0);
                rst = 1'b0;
                exp_rdata = 8'd0;
                return;
            end
        end
        checkOutput("done_latency", cyc, exp_lat);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("ack_err", ack_err, (!aack || (!r && !dack)) ? 1 : 0);
        if (r && aack) exp_rdata = rb;
        checkOutput("rdata", rdata, exp_rdata);
        // A start presented in the done cycle must not launch a transaction
        start = 1'b1; addr = a; rw = r;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_on_done_ignored", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            abyte[7 - i] = line_bits[i];
            dbyte[7 - i] = line_bits[9 + i];
        end
        checkOutput("addr_byte", abyte, int'(a) * 2 + int'(r));
        checkOutput("start_cond", starts - base_starts, 1);
        checkOutput("stop_cond", stops - base_stops, 1);
        checkOutput("scl_pulses", rises, aack ? 19 : 10);
        if (aack) checkOutput("data_byte", dbyte, r ? rb : wd);
        if (r && aack) checkOutput("read_nack_released", rel18, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_scl_out", scl_out, 1);
        checkOutput("reset_sda_enable", sda_enable, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ack_err", ack_err, 0);
        checkOutput("reset_rdata", rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
        applyStimulus(7'h51, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 0);
        applyStimulus(7'h33, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 0);
        applyStimulus(7'h6E, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 0);
        applyStimulus(7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 2);
        repeat (4) @(negedge clk);
        applyStimulus(7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
        applyStimulus(7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1);
`ifdef I2C_MASTER_STRETCH_EN
        applyStimulus(7'h15, 1'b0, 8'h99, 1'b1, 1'b1, 8'h00, 3);
`endif
        for (int n = 0; n < 8; n++) begin
            applyStimulus(7'($urandom), 1'($urandom), 8'($urandom),
                          ($urandom_range(3) != 0), ($urandom_range(3) != 0), 8'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request one transaction; sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1: 0 = write, 1 = read; captured with start.
REQ-006 SHALL have port addr, input, 7: 7-bit target address; captured with start.
REQ-007 SHALL have port wdata, input, 8: byte to write; captured with start.
REQ-008 SHALL have port sda_in, input, 1: sampled SDA line level.
REQ-009 SHALL have port scl_in, input, 1: sampled SCL line level; used only with REQ-030.
REQ-010 SHALL have port scl_out, output, 1: SCL drive, push-pull.
REQ-011 SHALL have port sda_enable, output, 1: 1 pulls SDA low; 0 releases SDA.
REQ-012 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at the end of a transaction.
REQ-014 SHALL have port ack_err, output, 1: target NACKed the address or data; valid with done, held until the next start.
REQ-015 SHALL have port rdata, output, 8: received byte; valid with done when rw=1, held until the next read.

Function
REQ-016 SHALL run a quarter-tick counter that divides clk by CLK_DIV; the FSM advances one quarter per tick.
REQ-017 SHALL make every bit 4 quarters: Q0-Q1 SCL=0, with SDA changed on entry to Q0; Q2-Q3 SCL=1; sda_in sampled on the last clk of Q2.
REQ-018 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RNACK, STOP.
REQ-019 SHALL in IDLE drive scl_out=1 and sda_enable=0; start=1 captures inputs and moves to START.
REQ-020 SHALL in START keep SCL=1 throughout, with SDA released in Q0-Q1 and pulled low in Q2-Q3.
REQ-021 SHALL in ADDR send {addr,rw} MSB first over 8 bits.
REQ-022 SHALL in ADDR_ACK release SDA and sample; 0 leads to WDATA (rw=0) or RDATA (rw=1); 1 sets ack_err and leads to STOP.
REQ-023 SHALL in WDATA send wdata MSB first; WDATA_ACK samples ACK; NACK sets ack_err; either result leads to STOP.
REQ-024 SHALL in RDATA release SDA and shift in 8 bits MSB first; in RNACK release SDA (NACK, last byte) and then go to STOP.
REQ-025 SHALL in STOP drive Q0 SCL=0/SDA low, Q1 SCL=1/SDA low, Q2-Q3 SCL=1/SDA released; then pulse done, clear busy, and return to IDLE.
REQ-026 SHALL ignore start while busy; a start in the same cycle as done is also ignored.
REQ-027 SHALL give a transaction a fixed length of 20 bit-periods = 80*CLK_DIV clk cycles from start acceptance to done, including NACK paths (no stretch).

Reset
REQ-028 SHALL on rst=1 at a clock edge go to IDLE and set scl_out=1, sda_enable=0, busy=0, done=0, ack_err=0, rdata=0x00, and clear the counters.
REQ-029 SHALL on reset mid-transaction abort immediately without generating STOP; the next start begins with a fresh START.

Configuration
REQ-030 SHALL with I2C_MASTER_STRETCH_EN defined freeze the quarter counter while the FSM is in Q2/Q3, scl_out=1 and scl_in=0 (clock stretching), and resume when scl_in=1.
REQ-031 SHALL without I2C_MASTER_STRETCH_EN ignore scl_in and keep timing strictly per REQ-027.

Verification
REQ-032 SHALL verify write: CLK_DIV=4, addr=0x2A, rw=0, wdata=0xA5, slave ACKs both. SDA bytes must be 0x54 then 0xA5, done must come 320 cycles after start, and ack_err=0.
REQ-033 SHALL verify read: addr=0x51, rw=1, slave returns 0x3C. SDA address byte must be 0xA3, rdata=0x3C at done, and master must release SDA on the 9th bit (NACK).
REQ-034 SHALL verify address NACK: sda_in held 1. Expect ack_err=1, no data phase, done at 320 cycles, and SDA low->high while SCL=1 (STOP).
REQ-035 SHALL verify reset mid-transaction: assert rst during data bit 3. The next cycle must show scl_out=1, sda_enable=0, busy=0, and a new start must complete correctly.
REQ-036 SHALL verify start while busy: pulse start at cycle 100 of an active write. Exactly one done must occur and the captured addr must be unchanged.
REQ-037 SHALL verify stretching with I2C_MASTER_STRETCH_EN: hold scl_in=0 for 50 cycles in ADDR bit 2. done must be delayed by exactly 50 cycles.
